control_sequencer: RTL and testbench

//  Parametrised instruction-sequencing FSM for the microprocessor core. Fetches via MAR/IR/PC strobes,

---
 rtl/control_sequencer_if.sv | 54 +++++
 rtl/control_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
//------------------------------------------------------------------------------
// control_sequencer_if : instruction/strobe bundle between sequencer and core.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface control_sequencer_if #(
   parameter int OPC_W  = 8,
   parameter int RA_W   = 8,
   parameter int DATA_W = 8,
   parameter int PC_W   = 8
);
   logic [OPC_W+RA_W+DATA_W-1:0] i_instr;
   logic                         i_instr_valid;
   logic [PC_W-1:0]              i_pc_value;
   logic                         o_pc_load;
   logic [PC_W-1:0]              o_pc_load_val;
   logic                         o_pc_inc;
   logic                         o_mar_load;
   logic                         o_ir_load;
   logic                         o_reg_re;
   logic                         o_reg_we;
   logic [RA_W-1:0]              o_rd_addr_a;
   logic [RA_W-1:0]              o_rd_addr_b;
   logic [RA_W-1:0]              o_wr_addr;
   logic [DATA_W-1:0]            o_wr_data;
   logic                         o_mem_re;
   logic                         o_mem_we;
   logic [DATA_W-1:0]            o_mem_addr;
   logic [OPC_W-1:0]             o_alu_sel;
   logic [1:0]                   o_path_sel;
   logic [3:0]                   o_state_out;
   logic [OPC_W-1:0]             o_opcode_out;
   logic                         o_illegal_op;
   logic                         o_stack_err;

   modport master (
      input  i_instr, i_instr_valid, i_pc_value,
      output o_pc_load, o_pc_load_val, o_pc_inc, o_mar_load, o_ir_load,
             o_reg_re, o_reg_we, o_rd_addr_a, o_rd_addr_b, o_wr_addr, o_wr_data,
             o_mem_re, o_mem_we, o_mem_addr, o_alu_sel, o_path_sel,
             o_state_out, o_opcode_out, o_illegal_op, o_stack_err
   );

   modport slave (
      output i_instr, i_instr_valid, i_pc_value,
      input  o_pc_load, o_pc_load_val, o_pc_inc, o_mar_load, o_ir_load,
             o_reg_re, o_reg_we, o_rd_addr_a, o_rd_addr_b, o_wr_addr, o_wr_data,
             o_mem_re, o_mem_we, o_mem_addr, o_alu_sel, o_path_sel,
             o_state_out, o_opcode_out, o_illegal_op, o_stack_err
   );
endinterface

`default_nettype wire

// File: rtl/control_sequencer.sv
//------------------------------------------------------------------------------
// control_sequencer : fetch/decode/execute FSM with return-address stack.
// Optional macro CTRL_STACK_GUARD_EN: stack overflow/underflow traps to ERROR.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module control_sequencer #(
   parameter int OPC_W       = 8,
   parameter int RA_W        = 8,
   parameter int DATA_W      = 8,
   parameter int PC_W        = 8,
   parameter int STACK_DEPTH = 16
) (
   input  wire                 clk,
   input  wire                 rst_n,
   control_sequencer_if.master bus
);
   localparam int SP_W = $clog2(STACK_DEPTH) + 1;
   localparam int IX_W = SP_W - 1;
   localparam int IW   = OPC_W + RA_W + DATA_W;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0, S_FETCH_0 = 4'd1, S_FETCH_1 = 4'd2, S_FETCH_2 = 4'd3,
      S_DECODE = 4'd4, S_IMM = 4'd5, S_MEM_0 = 4'd6, S_MEM_1 = 4'd7,
      S_EX_0 = 4'd8, S_EX_1 = 4'd9, S_EX_2 = 4'd10, S_JMP = 4'd11,
      S_CALL = 4'd12, S_RET = 4'd13, S_ERROR = 4'd14
   } state_t;

   typedef enum logic [3:0] {
      K_ILL = 4'd0, K_IMM = 4'd1, K_SDIR = 4'd2, K_LDIR = 4'd3, K_MOV = 4'd4,
      K_ALU = 4'd5, K_CMP = 4'd6, K_JMP = 4'd7, K_CALL = 4'd8, K_RET = 4'd9
   } kind_t;

   function automatic kind_t f_kind(input logic [OPC_W-1:0] op);
      kind_t k;
      k = K_ILL;
      case (op)
         OPC_W'(8'h01), OPC_W'(8'h18): k = K_IMM;
         OPC_W'(8'h02):                k = K_SDIR;
         OPC_W'(8'h19):                k = K_LDIR;
         OPC_W'(8'h1A):                k = K_MOV;
         OPC_W'(8'h1B):                k = K_CMP;
         OPC_W'(8'h1C):                k = K_JMP;
         OPC_W'(8'h1D):                k = K_CALL;
         OPC_W'(8'h1E):                k = K_RET;
         OPC_W'(8'h03), OPC_W'(8'h04), OPC_W'(8'h05), OPC_W'(8'h06),
         OPC_W'(8'h07), OPC_W'(8'h08), OPC_W'(8'h09), OPC_W'(8'h0A),
         OPC_W'(8'h0D), OPC_W'(8'h0E), OPC_W'(8'h0F), OPC_W'(8'h10),
         OPC_W'(8'h11), OPC_W'(8'h12), OPC_W'(8'h14), OPC_W'(8'h15),
         OPC_W'(8'h16), OPC_W'(8'h17): k = K_ALU;
         default:                      k = K_ILL;
      endcase
      return k;
   endfunction

   state_t            r_state;
   kind_t             r_kind;
   logic [RA_W-1:0]   r_fa;
   logic [DATA_W-1:0] r_fb;
   logic [SP_W-1:0]   r_sp;
   logic [PC_W-1:0]   r_stack [STACK_DEPTH];

   logic              r_pc_load, r_pc_inc, r_mar_load, r_ir_load;
   logic              r_reg_re, r_reg_we, r_mem_re, r_mem_we;
   logic              r_illegal_op, r_stack_err;
   logic [PC_W-1:0]   r_pc_load_val;
   logic [RA_W-1:0]   r_rd_addr_a, r_rd_addr_b, r_wr_addr;
   logic [DATA_W-1:0] r_wr_data, r_mem_addr;
   logic [OPC_W-1:0]  r_alu_sel, r_opcode_out;
   logic [1:0]        r_path_sel;

   logic [OPC_W-1:0]  w_opc;
   logic [RA_W-1:0]   w_fa;
   logic [DATA_W-1:0] w_fb;
   kind_t             w_kind;
   logic              w_full, w_empty, w_call_err, w_ret_err, w_push;
   logic [IX_W-1:0]   w_push_idx, w_pop_idx;
   logic [PC_W-1:0]   w_top;
   logic [OPC_W-1:0]  w_alu_hold;

   assign w_opc  = bus.i_instr[IW-1 -: OPC_W];
   assign w_fa   = bus.i_instr[DATA_W +: RA_W];
   assign w_fb   = bus.i_instr[DATA_W-1:0];
   assign w_kind = f_kind(w_opc);

   assign w_full     = (r_sp == SP_W'(STACK_DEPTH));
   assign w_empty    = (r_sp == '0);
`ifdef CTRL_STACK_GUARD_EN
   assign w_call_err = w_full;
   assign w_ret_err  = w_empty;
`else
   assign w_call_err = 1'b0;
   assign w_ret_err  = 1'b0;
`endif
   // A full stack without the guard keeps rewriting its top entry.
   assign w_push     = (r_state == S_DECODE) && (r_kind == K_CALL) && !w_call_err;
   assign w_push_idx = w_full ? IX_W'(STACK_DEPTH - 1) : r_sp[IX_W-1:0];
   assign w_pop_idx  = IX_W'(r_sp - 1'b1);
   assign w_top      = w_empty ? '0 : r_stack[w_pop_idx];
   assign w_alu_hold = (r_kind == K_ALU || r_kind == K_CMP) ? r_opcode_out : '0;

   always_ff @(posedge clk) begin
      if (w_push) r_stack[w_push_idx] <= bus.i_pc_value;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;   r_kind <= K_ILL;      r_fa <= '0;          r_fb <= '0;
         r_sp <= '0;          r_pc_load <= 1'b0;    r_pc_load_val <= '0; r_pc_inc <= 1'b0;
         r_mar_load <= 1'b0;  r_ir_load <= 1'b0;    r_reg_re <= 1'b0;    r_reg_we <= 1'b0;
         r_rd_addr_a <= '0;   r_rd_addr_b <= '0;    r_wr_addr <= '0;     r_wr_data <= '0;
         r_mem_re <= 1'b0;    r_mem_we <= 1'b0;     r_mem_addr <= '0;    r_alu_sel <= '0;
         r_path_sel <= '0;    r_opcode_out <= '0;   r_illegal_op <= 1'b0; r_stack_err <= 1'b0;
      end else begin
         r_pc_load <= 1'b0;   r_pc_load_val <= '0;  r_pc_inc <= 1'b0;    r_mar_load <= 1'b0;
         r_ir_load <= 1'b0;   r_reg_re <= 1'b0;     r_reg_we <= 1'b0;    r_rd_addr_a <= '0;
         r_rd_addr_b <= '0;   r_wr_addr <= '0;      r_wr_data <= '0;     r_mem_re <= 1'b0;
         r_mem_we <= 1'b0;    r_mem_addr <= '0;     r_alu_sel <= '0;     r_illegal_op <= 1'b0;
         case (r_state)
            S_IDLE, S_IMM, S_MEM_1, S_EX_2, S_JMP, S_CALL, S_RET: begin
               r_state <= S_FETCH_0; r_mar_load <= 1'b1;
            end
            S_FETCH_0: begin r_state <= S_FETCH_1; r_ir_load <= 1'b1; r_pc_inc <= 1'b1; end
            S_FETCH_1: r_state <= S_FETCH_2;
            S_FETCH_2: begin
               if (bus.i_instr_valid) begin
                  r_state <= S_DECODE; r_kind <= w_kind; r_fa <= w_fa; r_fb <= w_fb;
                  r_opcode_out <= w_opc;
                  r_illegal_op <= (w_kind == K_ILL);
                  r_path_sel   <= (w_kind == K_IMM) ? 2'b10 :
                                  (w_kind == K_SDIR || w_kind == K_LDIR) ? 2'b01 : 2'b00;
               end
            end
            S_DECODE: begin
               case (r_kind)
                  K_IMM:  begin r_state <= S_IMM; r_reg_we <= 1'b1; r_wr_addr <= r_fa; r_wr_data <= r_fb; end
                  K_SDIR: begin r_state <= S_MEM_0; r_reg_re <= 1'b1; r_rd_addr_a <= r_fa; end
                  K_LDIR: begin r_state <= S_MEM_0; r_mem_re <= 1'b1; r_mem_addr <= r_fb; end
                  K_MOV:  begin r_state <= S_EX_0; r_reg_re <= 1'b1; r_rd_addr_a <= RA_W'(r_fb); end
                  K_ALU, K_CMP: begin
                     r_state <= S_EX_0; r_reg_re <= 1'b1; r_rd_addr_a <= r_fa;
                     r_rd_addr_b <= RA_W'(r_fb); r_alu_sel <= r_opcode_out;
                  end
                  K_JMP:  begin r_state <= S_JMP; r_pc_load <= 1'b1; r_pc_load_val <= PC_W'(r_fb); end
                  K_CALL: begin
                     if (w_call_err) begin
                        r_state <= S_ERROR; r_stack_err <= 1'b1;
                     end else begin
                        r_state <= S_CALL; r_pc_load <= 1'b1; r_pc_load_val <= PC_W'(r_fb);
                        if (!w_full) r_sp <= r_sp + 1'b1;
                     end
                  end
                  K_RET: begin
                     if (w_ret_err) begin
                        r_state <= S_ERROR; r_stack_err <= 1'b1;
                     end else begin
                        r_state <= S_RET; r_pc_load <= 1'b1; r_pc_load_val <= w_top;
                        if (!w_empty) r_sp <= r_sp - 1'b1;
                     end
                  end
                  default: begin r_state <= S_FETCH_0; r_mar_load <= 1'b1; end
               endcase
            end
            S_MEM_0: begin
               r_state <= S_MEM_1;
               if (r_kind == K_SDIR) begin r_mem_we <= 1'b1; r_mem_addr <= r_fb; end
               else begin r_reg_we <= 1'b1; r_wr_addr <= r_fa; end
            end
            S_EX_0: begin r_state <= S_EX_1; r_alu_sel <= w_alu_hold; end
            S_EX_1: begin
               r_state <= S_EX_2; r_alu_sel <= w_alu_hold;
               if (r_kind != K_CMP) begin r_reg_we <= 1'b1; r_wr_addr <= r_fa; end
            end
            S_ERROR: r_state <= S_ERROR;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_pc_load     = r_pc_load;
   assign bus.o_pc_load_val = r_pc_load_val;
   assign bus.o_pc_inc      = r_pc_inc;
   assign bus.o_mar_load    = r_mar_load;
   assign bus.o_ir_load     = r_ir_load;
   assign bus.o_reg_re      = r_reg_re;
   assign bus.o_reg_we      = r_reg_we;
   assign bus.o_rd_addr_a   = r_rd_addr_a;
   assign bus.o_rd_addr_b   = r_rd_addr_b;
   assign bus.o_wr_addr     = r_wr_addr;
   assign bus.o_wr_data     = r_wr_data;
   assign bus.o_mem_re      = r_mem_re;
   assign bus.o_mem_we      = r_mem_we;
   assign bus.o_mem_addr    = r_mem_addr;
   assign bus.o_alu_sel     = r_alu_sel;
   assign bus.o_path_sel    = r_path_sel;
   assign bus.o_state_out   = r_state;
   assign bus.o_opcode_out  = r_opcode_out;
   assign bus.o_illegal_op  = r_illegal_op;
   assign bus.o_stack_err   = r_stack_err;
endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
//------------------------------------------------------------------------------
// tb_control_sequencer : directed self-checking bench for control_sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_control_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_miss = 0;

   always #5 clk = ~clk;

   control_sequencer_if bus ();

   control_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered with the FSM in FETCH_0; leaves it sitting in DECODE.
   task automatic fetch_to_decode(input logic [23:0] ins);
      bus.i_instr = ins;
      bus.i_instr_valid = 1'b1;
      tick();
      tick();
      tick();
      bus.i_instr_valid = 1'b0;
   endtask

   initial begin
      bus.i_instr = '0;
      bus.i_instr_valid = 1'b0;
      bus.i_pc_value = 8'h00;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", bus.o_state_out, 0);
      chk("rst_mar_load", bus.o_mar_load, 0);
      chk("rst_stack_err", bus.o_stack_err, 0);
      #2 rst_n = 1'b1;

      // Run ADD into EX_1 and abort it with an asynchronous reset
      tick();
      chk("first_fetch0", bus.o_state_out, 1);
      fetch_to_decode({8'h03, 8'h01, 8'h02});
      chk("add_decode", bus.o_state_out, 4);
      chk("add_opcode_out", bus.o_opcode_out, 8'h03);
      tick();
      chk("add_ex0_state", bus.o_state_out, 8);
      chk("add_ex0_reg_re", bus.o_reg_re, 1);
      chk("add_ex0_rd_a", bus.o_rd_addr_a, 8'h01);
      chk("add_ex0_rd_b", bus.o_rd_addr_b, 8'h02);
      chk("add_ex0_alu", bus.o_alu_sel, 8'h03);
      tick();
      chk("add_ex1_state", bus.o_state_out, 9);
      chk("add_ex1_reg_re", bus.o_reg_re, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_state", bus.o_state_out, 0);
      chk("midrst_alu", bus.o_alu_sel, 0);
      chk("midrst_opcode", bus.o_opcode_out, 0);
      chk("midrst_rd_a", bus.o_rd_addr_a, 0);
      #2 rst_n = 1'b1;

      tick();
      chk("f0_state", bus.o_state_out, 1);
      chk("f0_mar_load", bus.o_mar_load, 1);
      tick();
      chk("f1_state", bus.o_state_out, 2);
      chk("f1_ir_load", bus.o_ir_load, 1);
      chk("f1_pc_inc", bus.o_pc_inc, 1);
      chk("f1_mar_load", bus.o_mar_load, 0);
      tick();
      chk("f2_state", bus.o_state_out, 3);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("f2_wait_state", bus.o_state_out, 3);
      end
      bus.i_instr = {8'h01, 8'h03, 8'h5A};
      bus.i_instr_valid = 1'b1;
      tick();
      bus.i_instr_valid = 1'b0;
      chk("strimm_decode", bus.o_state_out, 4);
      tick();
      chk("strimm_state", bus.o_state_out, 5);
      chk("strimm_reg_we", bus.o_reg_we, 1);
      chk("strimm_wr_addr", bus.o_wr_addr, 8'h03);
      chk("strimm_wr_data", bus.o_wr_data, 8'h5A);
      chk("strimm_path", bus.o_path_sel, 2'b10);
      tick();
      chk("strimm_after_state", bus.o_state_out, 1);
      chk("strimm_after_we", bus.o_reg_we, 0);

      // Full ADD, then CMP
      fetch_to_decode({8'h03, 8'h01, 8'h02});
      chk("add_path", bus.o_path_sel, 2'b00);
      tick();
      tick();
      tick();
      chk("add_ex2_state", bus.o_state_out, 10);
      chk("add_ex2_reg_we", bus.o_reg_we, 1);
      chk("add_ex2_wr_addr", bus.o_wr_addr, 8'h01);
      chk("add_ex2_alu", bus.o_alu_sel, 8'h03);
      tick();
      fetch_to_decode({8'h1B, 8'h01, 8'h02});
      tick();
      chk("cmp_ex0_alu", bus.o_alu_sel, 8'h1B);
      chk("cmp_ex0_rd_b", bus.o_rd_addr_b, 8'h02);
      tick();
      tick();
      chk("cmp_ex2_state", bus.o_state_out, 10);
      chk("cmp_ex2_reg_we", bus.o_reg_we, 0);
      chk("cmp_ex2_alu", bus.o_alu_sel, 8'h1B);
      tick();

      // MOV r4 <- r7
      fetch_to_decode({8'h1A, 8'h04, 8'h07});
      tick();
      chk("mov_ex0_rd_a", bus.o_rd_addr_a, 8'h07);
      chk("mov_ex0_alu", bus.o_alu_sel, 0);
      tick();
      tick();
      chk("mov_ex2_we", bus.o_reg_we, 1);
      chk("mov_ex2_wr_addr", bus.o_wr_addr, 8'h04);
      tick();

      // STR_DIR and LOA_DIR
      fetch_to_decode({8'h02, 8'h05, 8'h80});
      chk("strdir_path", bus.o_path_sel, 2'b01);
      tick();
      chk("strdir_mem0_state", bus.o_state_out, 6);
      chk("strdir_mem0_rd_a", bus.o_rd_addr_a, 8'h05);
      tick();
      chk("strdir_mem1_we", bus.o_mem_we, 1);
      chk("strdir_mem1_addr", bus.o_mem_addr, 8'h80);
      tick();
      fetch_to_decode({8'h19, 8'h06, 8'h81});
      tick();
      chk("loadir_mem0_re", bus.o_mem_re, 1);
      chk("loadir_mem0_addr", bus.o_mem_addr, 8'h81);
      tick();
      chk("loadir_mem1_state", bus.o_state_out, 7);
      chk("loadir_mem1_wr_addr", bus.o_wr_addr, 8'h06);
      chk("loadir_mem1_we", bus.o_reg_we, 1);
      tick();

      // JMP, CALL/RET pair
      fetch_to_decode({8'h1C, 8'h00, 8'h33});
      tick();
      chk("jmp_state", bus.o_state_out, 11);
      chk("jmp_val", bus.o_pc_load_val, 8'h33);
      tick();
      bus.i_pc_value = 8'h11;
      fetch_to_decode({8'h1D, 8'h00, 8'h40});
      tick();
      chk("call_state", bus.o_state_out, 12);
      chk("call_pc_load", bus.o_pc_load, 1);
      chk("call_val", bus.o_pc_load_val, 8'h40);
      tick();
      bus.i_pc_value = 8'h77;
      fetch_to_decode({8'h1E, 8'h00, 8'h00});
      tick();
      chk("ret_state", bus.o_state_out, 13);
      chk("ret_val", bus.o_pc_load_val, 8'h11);
      chk("ret_sp", dut.r_sp, 0);
      tick();

      // Illegal opcode
      fetch_to_decode({8'hFF, 8'h12, 8'h34});
      chk("ill_pulse", bus.o_illegal_op, 1);
      chk("ill_reg_we", bus.o_reg_we, 0);
      chk("ill_mem_we", bus.o_mem_we, 0);
      chk("ill_pc_load", bus.o_pc_load, 0);
      tick();
      chk("ill_next_state", bus.o_state_out, 1);
      chk("ill_pulse_end", bus.o_illegal_op, 0);
      chk("ill_reg_re", bus.o_reg_re, 0);

`ifndef CTRL_STACK_GUARD_EN
      fetch_to_decode({8'h1E, 8'h00, 8'h00});
      tick();
      chk("ret_empty_load", bus.o_pc_load, 1);
      chk("ret_empty_val", bus.o_pc_load_val, 0);
      chk("ret_empty_sp", dut.r_sp, 0);
      tick();
`endif

      // 17 nested CALLs, return address 0x20+i
      for (int i = 0; i < 17; i++) begin
         bus.i_pc_value = 8'(8'h20 + i);
         fetch_to_decode({8'h1D, 8'h00, 8'h40});
         tick();
         if (i < 16) begin
            chk("nest_call_state", bus.o_state_out, 12);
            tick();
         end
      end
`ifdef CTRL_STACK_GUARD_EN
      chk("guard_err_state", bus.o_state_out, 14);
      chk("guard_stack_err", bus.o_stack_err, 1);
      chk("guard_no_pc_load", bus.o_pc_load, 0);
      tick();
      tick();
      chk("guard_err_held", bus.o_state_out, 14);
      chk("guard_err_sticky", bus.o_stack_err, 1);
      chk("guard_sp", dut.r_sp, 16);
`else
      chk("full_call_state", bus.o_state_out, 12);
      chk("full_call_val", bus.o_pc_load_val, 8'h40);
      chk("full_stack_err", bus.o_stack_err, 0);
      chk("full_sp", dut.r_sp, 16);
      tick();
      fetch_to_decode({8'h1E, 8'h00, 8'h00});
      tick();
      chk("full_ret1_val", bus.o_pc_load_val, 8'h30);
      chk("full_ret1_sp", dut.r_sp, 15);
      tick();
      fetch_to_decode({8'h1E, 8'h00, 8'h00});
      tick();
      chk("full_ret2_val", bus.o_pc_load_val, 8'h2E);
      chk("full_ret_stack_err", bus.o_stack_err, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

`default_nettype wire
